// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths, types and constants for the register file and its scoreboard.
package regfile_scoreboard_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;
  // Must be wide enough to hold NUM_REGS-1 (every register except x0 busy).
  localparam int CNT_WIDTH      = 6;

  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
  typedef logic [CNT_WIDTH-1:0]      cnt_t;

  // x0 reads as zero, ignores writes and is never tracked as busy.
  localparam addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing signal bundle of the register file.
// master = decode + writeback side, slave = register file.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  // Read ports
  addr_t rs1_addr;
  addr_t rs2_addr;
  logic  rd_req;
  data_t rs1_data;
  data_t rs2_data;

  // Issue (scoreboard set)
  logic  issue_valid;
  addr_t issue_rd;

  // Writeback (register write + scoreboard clear)
  logic  wb_en;
  addr_t wb_addr;
  data_t wb_data;

  // Status back to decode
  logic  raw_hazard;
  logic  waw_hazard;
  cnt_t  pending_cnt;

  modport master (
    output rs1_addr, rs2_addr, rd_req,
    output issue_valid, issue_rd,
    output wb_en, wb_addr, wb_data,
    input  rs1_data, rs2_data,
    input  raw_hazard, waw_hazard, pending_cnt
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_req,
    input  issue_valid, issue_rd,
    input  wb_en, wb_addr, wb_data,
    output rs1_data, rs2_data,
    output raw_hazard, waw_hazard, pending_cnt
  );

endinterface

// File: rtl/regfile_scoreboard_reg_scoreboard.sv
// Pending-write scoreboard: busy bit per register, busy count and
// RAW/WAW hazard flags. A set and a clear of the same register in one
// cycle leaves it busy, because the newly issued producer owns it.
module reg_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  issue_valid,
  input  addr_t issue_rd,
  input  logic  wb_en,
  input  addr_t wb_addr,
  input  addr_t rs1_addr,
  input  addr_t rs2_addr,
  output logic  raw_hazard,
  output logic  waw_hazard,
  output cnt_t  pending_cnt
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                set_hit;
  logic                clr_hit;
  logic                cnt_inc;
  logic                cnt_dec;

  // A writeback completing this cycle to a non-x0 register.
  function automatic logic clr_now(input logic en, input addr_t wa, input addr_t a);
    return en && (wa == a) && (a != ZERO_REG);
  endfunction

  assign set_hit = issue_valid && (issue_rd != ZERO_REG);
  assign clr_hit = wb_en && (wb_addr != ZERO_REG);

  // Next busy vector: clear first, then set, so set wins on the same index.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (clr_hit) busy_next[wb_addr] = 1'b0;
    if (set_hit) busy_next[issue_rd] = 1'b1;
    busy_next[ZERO_REG] = 1'b0;
  end

  // Incremental popcount: +1 for a fresh set, -1 for a clear not overridden by a set.
  assign cnt_inc = set_hit && !busy[issue_rd];
  assign cnt_dec = clr_hit && busy[wb_addr] && !(set_hit && (issue_rd == wb_addr));

  // Busy vector and count state.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_next;
      pending_cnt <= pending_cnt + cnt_t'(cnt_inc) - cnt_t'(cnt_dec);
    end
  end

  // A completing writeback is bypassed to the reader, so it does not stall.
  assign raw_hazard = (busy[rs1_addr] && !clr_now(wb_en, wb_addr, rs1_addr)) ||
                      (busy[rs2_addr] && !clr_now(wb_en, wb_addr, rs2_addr));

  assign waw_hazard = issue_valid && busy[issue_rd] && !clr_now(wb_en, wb_addr, issue_rd);

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with two registered read ports, write-to-read
// bypass and a pending-write scoreboard for decode stalls.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  data_t regs [NUM_REGS];
  data_t rs1_next;
  data_t rs2_next;
  logic  wr_en;

  assign wr_en = bus.wb_en && (bus.wb_addr != ZERO_REG);

  // Read value per port: x0 is zero, a same-cycle write is forwarded.
  always_comb begin
    rs1_next = regs[bus.rs1_addr];
    rs2_next = regs[bus.rs2_addr];
    if (bus.rs1_addr == ZERO_REG)                  rs1_next = '0;
    else if (wr_en && (bus.wb_addr == bus.rs1_addr)) rs1_next = bus.wb_data;
    if (bus.rs2_addr == ZERO_REG)                  rs2_next = '0;
    else if (wr_en && (bus.wb_addr == bus.rs2_addr)) rs2_next = bus.wb_data;
  end

  // Register storage; x0 is never written.
  // NOTE: the array is reset because every architectural register must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Registered read ports, held while no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rs1_data <= '0;
      bus.rs2_data <= '0;
    end else if (bus.rd_req) begin
      bus.rs1_data <= rs1_next;
      bus.rs2_data <= rs2_next;
    end
  end

  reg_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .wb_en       (bus.wb_en),
    .wb_addr     (bus.wb_addr),
    .rs1_addr    (bus.rs1_addr),
    .rs2_addr    (bus.rs2_addr),
    .raw_hazard  (bus.raw_hazard),
    .waw_hazard  (bus.waw_hazard),
    .pending_cnt (bus.pending_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: plain arrays updated from the inputs seen at each edge.
  data_t m_regs [NUM_REGS];
  bit    m_busy [NUM_REGS];
  data_t m_rs1, m_rs2;
  int    m_cnt;
  bit    m_valid = 0;

  function automatic data_t m_read(input addr_t a);
    if (a == 0) return '0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_pending(input addr_t a);
    return m_busy[a] && !(bus.wb_en && bus.wb_addr == a && a != 0);
  endfunction

  // Compare process: advance the model at each edge, check outputs 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          m_regs[i] = '0;
          m_busy[i] = 0;
        end
        m_rs1   = '0;
        m_rs2   = '0;
        m_valid = 1;
      end else if (m_valid) begin
        if (bus.rd_req) begin
          m_rs1 = m_read(bus.rs1_addr);
          m_rs2 = m_read(bus.rs2_addr);
        end
        if (bus.wb_en && bus.wb_addr != 0) begin
          m_regs[bus.wb_addr] = bus.wb_data;
          m_busy[bus.wb_addr] = 0;
        end
        if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
      end
      m_cnt = 0;
      for (int i = 0; i < NUM_REGS; i++) m_cnt += int'(m_busy[i]);
      #1;
      if (m_valid) begin
        check("rs1_data", bus.rs1_data, m_rs1);
        check("rs2_data", bus.rs2_data, m_rs2);
        check("pending_cnt", 32'(bus.pending_cnt), 32'(m_cnt));
        check("raw_hazard", 32'(bus.raw_hazard),
              32'(m_pending(bus.rs1_addr) || m_pending(bus.rs2_addr)));
        check("waw_hazard", 32'(bus.waw_hazard),
              32'(bus.issue_valid && m_pending(bus.issue_rd)));
      end
    end
  end

  // Returns 2 time units after the next rising edge, past the compare point.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.rd_req      = 1'b0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
  endtask

  // Random index biased toward a few low registers to provoke collisions.
  function automatic addr_t pick_addr();
    if ($urandom_range(0, 3) == 0) return addr_t'($urandom_range(0, NUM_REGS - 1));
    return addr_t'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reads after reset return zero.
    bus.rd_req = 1'b1; bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd0;
    tick();
    check("lit_reset_rs1", bus.rs1_data, 32'h0);
    check("lit_reset_rs2", bus.rs2_data, 32'h0);
    check("lit_reset_cnt", 32'(bus.pending_cnt), 32'd0);
    check("lit_reset_raw", 32'(bus.raw_hazard), 32'd0);

    // Write with same-cycle read bypass, then a plain read.
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF; bus.rs1_addr = 5'd5;
    tick();
    check("lit_bypass", bus.rs1_data, 32'hDEADBEEF);
    bus.wb_en = 1'b0;
    tick();
    check("lit_read_x5", bus.rs1_data, 32'hDEADBEEF);

    // Write to x0 is dropped.
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234; bus.rs1_addr = 5'd0;
    tick();
    bus.wb_en = 1'b0;
    tick();
    check("lit_x0_read", bus.rs1_data, 32'h0);
    check("lit_x0_cnt", 32'(bus.pending_cnt), 32'd0);

    // RAW hazard on x7, released by its own writeback.
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 1'b0; bus.rs2_addr = 5'd7;
    #1;
    check("lit_raw_set", 32'(bus.raw_hazard), 32'd1);
    check("lit_cnt_one", 32'(bus.pending_cnt), 32'd1);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h77;
    #1;
    check("lit_raw_bypass", 32'(bus.raw_hazard), 32'd0);
    tick();
    bus.wb_en = 1'b0;
    check("lit_cnt_cleared", 32'(bus.pending_cnt), 32'd0);

    // Same-index set and clear keeps the register busy; re-issue flags WAW.
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    tick();
    bus.wb_en = 1'b0;
    check("lit_setclr_cnt", 32'(bus.pending_cnt), 32'd1);
    #1;
    check("lit_waw", 32'(bus.waw_hazard), 32'd1);
    bus.issue_valid = 1'b0;
    tick();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9;
    tick();
    bus.wb_en = 1'b0;
    check("lit_x9_done", 32'(bus.pending_cnt), 32'd0);

    // Fill the scoreboard, drain a few, then reset with traffic present.
    for (int i = 1; i < NUM_REGS; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = addr_t'(i);
      tick();
    end
    bus.issue_valid = 1'b0;
    check("lit_cnt_full", 32'(bus.pending_cnt), 32'd31);
    for (int i = 1; i <= 5; i++) begin
      bus.wb_en = 1'b1; bus.wb_addr = addr_t'(i); bus.wb_data = 32'(i * 32'h11);
      tick();
    end
    check("lit_cnt_drain", 32'(bus.pending_cnt), 32'd26);
    reset = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'hCAFE0006;
    tick();
    reset = 1'b0;
    idle();
    bus.rs1_addr = 5'd10; bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    #1;
    check("lit_rst_cnt", 32'(bus.pending_cnt), 32'd0);
    check("lit_rst_raw", 32'(bus.raw_hazard), 32'd0);
    check("lit_rst_waw", 32'(bus.waw_hazard), 32'd0);
    bus.issue_valid = 1'b0;
    bus.rd_req = 1'b1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
    tick();
    check("lit_rst_rs1", bus.rs1_data, 32'h0);
    check("lit_rst_rs2", bus.rs2_data, 32'h0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 99) == 0);
      bus.rd_req      = $urandom_range(0, 1) == 1;
      bus.rs1_addr    = pick_addr();
      bus.rs2_addr    = pick_addr();
      bus.issue_valid = $urandom_range(0, 2) == 0;
      bus.issue_rd    = pick_addr();
      bus.wb_en       = $urandom_range(0, 1) == 1;
      bus.wb_addr     = pick_addr();
      bus.wb_data     = $urandom;
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural integer register file plus pending-write scoreboard.
- Sits directly downstream of the writeback stage and consumes its registered write port (address, data, enable).
- Serves two registered read ports to decode, with write-to-read bypass.
- Tracks destination registers issued but not yet written back, and raises RAW/WAW hazard flags so decode can stall.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- REG_ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- CNT_WIDTH, 6, width of the pending-write counter; must hold NUM_REGS-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rs1_addr  in  REG_ADDR_WIDTH  read port 1 source index (from decode).
- rs2_addr  in  REG_ADDR_WIDTH  read port 2 source index.
- rd_req  in  1  read request; the read ports sample only when high.
- rs1_data  out  DATA_WIDTH  registered read data, port 1.
- rs2_data  out  DATA_WIDTH  registered read data, port 2.
- issue_valid  in  1  decode issues a uop that writes issue_rd.
- issue_rd  in  REG_ADDR_WIDTH  destination of the issued uop.
- wb_en  in  1  writeback write enable.
- wb_addr  in  REG_ADDR_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback data.
- raw_hazard  out  1  combinational; rs1 or rs2 is pending.
- waw_hazard  out  1  combinational; issue_rd is pending.
- pending_cnt  out  CNT_WIDTH  registered count of busy registers.

Behaviour:
Reset:
- Synchronous, active-high; takes effect at the first rising edge with reset high.
- All registers clear to 0 and all busy bits clear.
- rs1_data, rs2_data and pending_cnt clear to 0.
- raw_hazard and waw_hazard are therefore 0.
- Reset mid-operation discards all pending state, and wb_en/issue_valid are ignored in that cycle.

Write:
- On the edge where wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
- A write to x0 is dropped.

Read:
- One-cycle latency: on an edge with rd_req=1, rsN_data <= value of reg[rsN_addr].
- If rsN_addr==0 the value is 0.
- If wb_en=1 and wb_addr==rsN_addr!=0 in the same cycle, the value is wb_data (bypass; new data wins).
- With rd_req=0, rsN_data holds its previous value.

Scoreboard:
- busy[NUM_REGS-1:1]; busy[0] is constant 0.
- Set: issue_valid=1 and issue_rd!=0 sets busy[issue_rd] at the edge.
- Clear: wb_en=1 and wb_addr!=0 clears busy[wb_addr] at the edge.
- Simultaneous set and clear on the same index: set wins, busy stays 1 (the new producer owns the register).
- A clear of a non-busy register is legal: data is written, busy is unaffected.
- raw_hazard = (busy[rs1_addr] & ~clr_now(rs1_addr)) | (busy[rs2_addr] & ~clr_now(rs2_addr)).
  - clr_now(a) = wb_en & wb_addr==a & a!=0.
  - The completing write is bypassed, so it does not stall.
- waw_hazard = busy[issue_rd] & ~clr_now(issue_rd), gated by issue_valid.
- Decode must not issue while waw_hazard=1. An issue to an already-busy rd is a protocol error: busy stays 1 and the count is unchanged.

Counter:
- pending_cnt next = popcount(next busy vector), maintained incrementally.
- +1 when a not-busy register is set.
- -1 when a busy register is cleared without a simultaneous set.
- Net 0 for same-index set plus clear, or for a set of one index and a clear of another.
- Never wraps: maximum is NUM_REGS-1 and minimum is 0.

Decomposition:
- Shared package/header holds DATA_WIDTH, REG_ADDR_WIDTH, NUM_REGS, CNT_WIDTH and the x0 index constant (ZERO_REG=0).
- Separate sub-module reg_scoreboard holds:
  - the busy vector and counter;
  - the set/clear priority;
  - the hazard outputs.
- The top level holds the storage array, read registers and bypass.

Test Plan:
- Reset, then rd_req with rs1=3, rs2=0 -> next cycle rs1_data=0, rs2_data=0, pending_cnt=0, raw_hazard=0.
- wb_en, wb_addr=5, wb_data=0xDEADBEEF, with rd_req and rs1=5 in the same cycle -> next cycle rs1_data=0xDEADBEEF (bypass); a later read of x5 also returns 0xDEADBEEF.
- wb_en, wb_addr=0, wb_data=0x1234 -> a read of x0 returns 0, pending_cnt unchanged.
- issue rd=7; next cycle rs2=7 -> raw_hazard=1, pending_cnt=1; then wb_addr=7 with rs2=7 held -> raw_hazard=0 in that cycle, pending_cnt=0 next edge.
- issue rd=9 with wb_en wb_addr=9 in the same cycle (busy[9] already 1) -> busy[9] stays 1, pending_cnt unchanged; issue rd=9 while busy -> waw_hazard=1.
- Issue x1..x31 on consecutive cycles -> pending_cnt=31; assert reset mid-sequence -> pending_cnt=0, all hazards 0, reads return 0 next cycle.
